// File: rtl/key_io_device.sv
// Memory-mapped push-button peripheral: synchronizes and debounces four
// active-low keys, latches a ready/overrun status and raises an interrupt.
module key_io_device #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [DBITS-1:0] addr,
  input  logic             rdEn,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] dataIn,
  output logic [DBITS-1:0] dataOut,
  output logic             hit,
  output logic             intr
);

  localparam logic [15:0] LAST_CNT = DEBOUNCE_CYCLES - 16'd1;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_key_state;
  logic [3:0][15:0] r_cnt;
  logic             r_ready;
  logic             r_overrun;
  logic             r_ie;

  logic [3:0]       w_accept;
  logic             w_change;
  logic             w_key_rd;
  logic             w_ctrl_rd;
  logic             w_ctrl_wr;
  logic [DBITS-1:0] w_key_word;
  logic [DBITS-1:0] w_ctrl_word;
  logic             w_unused;

  // Bus access is strobe based: rdEn/wrtEn are single-cycle requests that
  // complete in the cycle they are asserted; there is no back-pressure.
  assign w_key_rd  = rdEn  && (addr == ADDR_KEY);
  assign w_ctrl_rd = rdEn  && (addr == ADDR_KCTRL);
  assign w_ctrl_wr = wrtEn && (addr == ADDR_KCTRL);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= ~KEY;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_accept = 4'b0;
    for (int i = 0; i < 4; i++) begin
      w_accept[i] = (r_sync2[i] != r_key_state[i]) && (r_cnt[i] >= LAST_CNT);
    end
  end

  assign w_change = |w_accept;

  // Counter only runs while the sample disagrees with the accepted state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_state <= 4'b0;
      r_cnt       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_key_state[i]) begin
          r_cnt[i] <= 16'd0;
        end else if (w_accept[i]) begin
          r_key_state[i] <= r_sync2[i];
          r_cnt[i]       <= 16'd0;
        end else if (r_cnt[i] != 16'hFFFF) begin
          r_cnt[i] <= r_cnt[i] + 16'd1;
        end
      end
    end
  end

  // A new key event always wins over a clearing read or write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      if (w_change) begin
        r_ready <= 1'b1;
      end else if (w_key_rd) begin
        r_ready <= 1'b0;
      end

      if (w_change && r_ready && !w_key_rd) begin
        r_overrun <= 1'b1;
      end else if (w_ctrl_wr && !dataIn[2]) begin
        r_overrun <= 1'b0;
      end

      if (w_ctrl_wr) begin
        r_ie <= dataIn[8];
      end
    end
  end

  assign w_key_word  = {{(DBITS-4){1'b0}}, r_key_state};
  assign w_ctrl_word = {{(DBITS-9){1'b0}}, r_ie, 5'b0, r_overrun, 1'b0, r_ready};

  always_comb begin
    dataOut = '0;
    if (w_key_rd) begin
      dataOut = w_key_word;
    end else if (w_ctrl_rd) begin
      dataOut = w_ctrl_word;
    end
  end

  assign hit  = (addr == ADDR_KEY) || (addr == ADDR_KCTRL);
  assign intr = r_ready && r_ie;

  assign w_unused = ^{dataIn[DBITS-1:9], dataIn[7:3], dataIn[1:0]};

endmodule

// File: tb/tb_key_io_device.sv
// Bench for key_io_device: directed scenarios with literal expectations plus
// randomized key/bus traffic checked every cycle against a window-based model.
module tb_key_io_device;

  localparam int          DC     = 4;
  localparam logic [31:0] A_KEY  = 32'hF0000010;
  localparam logic [31:0] A_CTRL = 32'hF0000110;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  KEY    = 4'hF;
  logic [31:0] addr   = 32'h0;
  logic        rdEn   = 1'b0;
  logic        wrtEn  = 1'b0;
  logic [31:0] dataIn = 32'h0;
  logic [31:0] dataOut;
  logic        hit;
  logic        intr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  key_io_device #(
    .DBITS(32),
    .ADDR_KEY(A_KEY),
    .ADDR_KCTRL(A_CTRL),
    .DEBOUNCE_CYCLES(16'(DC))
  ) dut (
    .clk(clk),
    .reset(reset),
    .KEY(KEY),
    .addr(addr),
    .rdEn(rdEn),
    .wrtEn(wrtEn),
    .dataIn(dataIn),
    .dataOut(dataOut),
    .hit(hit),
    .intr(intr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a key bit flips once the last DC synchronized samples all
  // disagree with its accepted value; samples lag the pins by two edges.
  logic [3:0] m_ks;
  logic       m_rdy, m_ov, m_ie;
  logic [3:0] raw_q[$];
  logic [3:0] samp_q[$];
  bit         model_valid = 0;

  always @(posedge clk) begin : model
    logic [3:0] s, acc;
    logic chg, krd, cwr;
    bit all_diff;
    if (reset) begin
      m_ks = 4'h0; m_rdy = 1'b0; m_ov = 1'b0; m_ie = 1'b0;
      raw_q = {4'hF, 4'hF};
      samp_q.delete();
      model_valid = 1;
    end else begin
      s = ~raw_q[1];
      samp_q.push_front(s);
      if (samp_q.size() > DC) void'(samp_q.pop_back());
      acc = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if (samp_q.size() == DC) begin
          all_diff = 1;
          foreach (samp_q[i]) if (samp_q[i][b] == m_ks[b]) all_diff = 0;
          acc[b] = all_diff;
        end
      end
      chg = |acc;
      krd = rdEn && (addr == A_KEY);
      cwr = wrtEn && (addr == A_CTRL);
      if (chg && m_rdy && !krd) m_ov = 1'b1;
      else if (cwr && !dataIn[2]) m_ov = 1'b0;
      if (chg) m_rdy = 1'b1;
      else if (krd) m_rdy = 1'b0;
      if (cwr) m_ie = dataIn[8];
      m_ks = m_ks ^ acc;
      raw_q.push_front(KEY);
      if (raw_q.size() > 2) void'(raw_q.pop_back());
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] exp_data;
    if (model_valid) begin
      exp_data = 32'h0;
      if (rdEn && addr == A_KEY) exp_data = {28'h0, m_ks};
      else if (rdEn && addr == A_CTRL) exp_data = {23'h0, m_ie, 5'h0, m_ov, 1'b0, m_rdy};
      check("model_dataOut", dataOut, exp_data);
      check("model_hit", {31'h0, hit}, {31'h0, (addr == A_KEY) || (addr == A_CTRL)});
      check("model_intr", {31'h0, intr}, {31'h0, m_rdy & m_ie});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a;
    rdEn = 1'b1;
    @(negedge clk);
    check(name, dataOut, exp);
    @(posedge clk);
    #1;
    rdEn = 1'b0;
    addr = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    dataIn = d;
    wrtEn  = 1'b1;
    tick(1);
    wrtEn  = 1'b0;
    addr   = 32'h0;
    dataIn = 32'h0;
  endtask

  task automatic chk_intr(input logic exp, input string name);
    @(negedge clk);
    check(name, {31'h0, intr}, {31'h0, exp});
    @(posedge clk);
    #1;
  endtask

  int hold [4];

  initial begin
    tick(1);
    do_reset();
    check("reset_intr", {31'h0, intr}, 32'h0);
    check("reset_data", dataOut, 32'h0);

    // Idle keys: nothing accepted, status stays clear.
    for (int i = 0; i < 50; i++) begin
      rd(A_CTRL, 32'h0, "idle_kctrl");
      rd(A_KEY, 32'h0, "idle_key");
    end

    // Clean press of KEY[1]: accepted exactly 2+DC edges later.
    do_reset();
    KEY = 4'hD;
    tick(5);
    rd(A_CTRL, 32'h0, "press1_before");
    rd(A_CTRL, 32'h1, "press1_ready");
    rd(A_KEY, 32'h2, "press1_key");
    rd(A_CTRL, 32'h0, "press1_cleared");

    // Bouncing KEY[0] never holds long enough until it settles pressed.
    do_reset();
    KEY = 4'hF;
    for (int i = 0; i < 5; i++) begin
      KEY[0] = 1'b0; tick(2);
      KEY[0] = 1'b1; tick(2);
    end
    KEY[0] = 1'b0;
    tick(5);
    rd(A_CTRL, 32'h0, "bounce_before");
    rd(A_CTRL, 32'h1, "bounce_ready");
    rd(A_KEY, 32'h1, "bounce_key");

    // Two unread events produce overrun; clearing write keeps ready.
    do_reset();
    KEY = 4'hB;
    tick(8);
    KEY = 4'hF;
    tick(8);
    rd(A_CTRL, 32'h5, "overrun_set");
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, 32'h1, "overrun_clr");

    // Interrupt follows ready while enabled; key read drops it.
    do_reset();
    KEY = 4'hF;
    wr(A_CTRL, 32'h100);
    KEY = 4'h7;
    tick(5);
    chk_intr(1'b0, "intr_before");
    chk_intr(1'b1, "intr_rise");
    rd(A_KEY, 32'h8, "intr_key");
    chk_intr(1'b0, "intr_fall");

    // Event coincident with a key read: ready set, no overrun.
    do_reset();
    KEY = 4'hE;
    tick(5);
    rd(A_KEY, 32'h0, "coinc_key");
    rd(A_CTRL, 32'h1, "coinc_kctrl");

    // Reset in mid-debounce discards progress; held key re-accepted later.
    KEY = 4'hF;
    do_reset();
    KEY = 4'hD;
    tick(3);
    reset = 1'b1;
    rd(A_CTRL, 32'h0, "rst_mid0");
    rd(A_CTRL, 32'h0, "rst_mid1");
    reset = 1'b0;
    tick(5);
    rd(A_CTRL, 32'h0, "rst_hold_before");
    rd(A_CTRL, 32'h1, "rst_hold_ready");
    rd(A_KEY, 32'h2, "rst_hold_key");

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    KEY = 4'hF;
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          KEY[b]  = 1'($urandom_range(0, 1));
          hold[b] = $urandom_range(1, 9);
        end else begin
          hold[b]--;
        end
      end
      case ($urandom_range(0, 3))
        0: addr = A_KEY;
        1: addr = A_CTRL;
        2: addr = $urandom;
        default: addr = A_KEY + 32'h4;
      endcase
      rdEn   = ($urandom_range(0, 9) < 4);
      wrtEn  = ($urandom_range(0, 5) == 0);
      dataIn = $urandom;
      reset  = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rdEn  = 1'b0;
    wrtEn = 1'b0;
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_io_device.md
KEY_IO_DEVICE -- requirements
Module: key_io_device

Interface
REQ-001 Parameter DBITS, 32, bus data width.
REQ-002 Parameter ADDR_KEY, 32'hF0000010, key data register address.
REQ-003 Parameter ADDR_KCTRL, 32'hF0000110, key control/status register address.
REQ-004 Parameter DEBOUNCE_CYCLES, 16'd50000, consecutive stable samples required before a key change is accepted.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 KEY  input  4  raw board push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-008 addr  input  DBITS  memory-stage address (pipelined ALU result).
REQ-009 rdEn  input  1  memory-stage load strobe, one cycle per access.
REQ-010 wrtEn  input  1  memory-stage store strobe, one cycle per access.
REQ-011 dataIn  input  DBITS  store data.
REQ-012 dataOut  output  DBITS  load data returned to the memory-stage result mux.
REQ-013 hit  output  1  high when addr equals ADDR_KEY or ADDR_KCTRL.
REQ-014 intr  output  1  interrupt request = ready & ie.

Function
REQ-015 ~KEY SHALL pass through a 2-flop synchronizer per bit; synchronized value is "sample".
REQ-016 Each bit SHALL have a 16-bit stability counter: reset to 0 when sample equals keyState, else increment; when it reaches DEBOUNCE_CYCLES-1 and sample still differs, keyState bit SHALL take sample and the counter SHALL clear.
REQ-017 Counter SHALL saturate, never wrap; DEBOUNCE_CYCLES=1 SHALL accept a change on the first differing sample.
REQ-018 Total latency from a clean KEY edge to keyState change SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-019 "change" SHALL be asserted in any cycle where one or more keyState bits update.
REQ-020 KCTRL layout: bit0 ready, bit2 overrun, bit8 ie; all other bits read 0.
REQ-021 Read of ADDR_KEY (rdEn & addr==ADDR_KEY) SHALL return {28'b0, keyState} combinationally, reflecting the pre-edge value, and SHALL clear ready at the clock edge.
REQ-022 Read of ADDR_KCTRL SHALL return {23'b0, ie, 5'b0, overrun, 1'b0, ready} with no side effects.
REQ-023 dataOut SHALL be 0 whenever rdEn is low or hit is low.
REQ-024 change with ready=0 SHALL set ready; change with ready=1 and no same-cycle ADDR_KEY read SHALL set overrun and keep ready=1.
REQ-025 change coincident with an ADDR_KEY read: set wins, ready stays 1, overrun unchanged.
REQ-026 Write to ADDR_KCTRL: ie <= dataIn[8]; dataIn[2]=0 clears overrun, dataIn[2]=1 leaves it; bit0 ignored (ready not writable).
REQ-027 overrun set by change in the same cycle as a clearing write SHALL remain 1 (set wins).
REQ-028 Writes to ADDR_KEY and reads/writes to any other address SHALL have no effect.
REQ-029 rdEn and wrtEn both high in one cycle SHALL perform both actions independently.

Reset
REQ-030 While reset is high at a clock edge: synchronizer flops, keyState, all counters, ready, overrun, ie SHALL become 0; dataOut=0 and intr=0 from the following cycle.
REQ-031 Reset mid-debounce SHALL discard the pending change; a key held through reset SHALL be accepted 2+DEBOUNCE_CYCLES cycles after reset deasserts.

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Reset, KEY=4'hF held -> keyState=0, KCTRL reads 0, intr=0 for 100 cycles.
REQ-033 KEY[1]->0 clean at cycle 10 -> keyState=4'h2 at cycle 16, ready=1; ADDR_KEY read returns 32'h2, next KCTRL read returns 32'h0.
REQ-034 KEY[0] toggles every 2 cycles for 20 cycles then settles at 0 -> exactly one keyState update, 6 cycles after settling, to 4'h1.
REQ-035 Press KEY[2], no read, then release -> ready=1, overrun=1 (KCTRL=32'h5); write 32'h0 to KCTRL -> KCTRL=32'h1.
REQ-036 Write 32'h100 to KCTRL, press KEY[3] -> intr rises with ready; ADDR_KEY read returns 32'h8, intr falls next cycle.
REQ-037 Change coincident with ADDR_KEY read -> ready=1, overrun=0 afterwards; reset asserted mid-debounce -> no ready set before reset release.
